// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory request path: access sizes, responder states
// and the alignment check applied to every accepted request.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Reserved size, odd half address or non-word-aligned word address.
  function automatic logic misalign_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = off[0];
      SZ_WORD: err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load lane select plus sign/zero extension; purely combinational, no flow control.
// Word accesses pass through unchanged and ignore is_unsigned.
module dm_lane_ext
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word >> {off, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = off[1] ? word[31:16] : word[15:0];
    data    = word;
    case (size)
      SZ_BYTE: data = is_unsigned ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: data = is_unsigned ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, response valid WAIT_CYCLES+1 cycles after acceptance.
// Response is held stable under rsp_ready backpressure; no new request is accepted until it is consumed.
module dm_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem_q [DEPTH];

  logic              accept;
  logic              acc_err;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic [ADDR_W+1:0] rd_addr;
  logic [1:0]        rd_size;
  logic              rd_uns;
  logic              rd_we;
  logic              rd_err;
  logic [31:0]       rd_word;
  logic [31:0]       rd_ext;
  logic              unused_addr_hi;

  assign accept         = req_valid && req_ready_q;
  assign acc_err        = misalign_err(req_size, req_addr[1:0]);
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Store lanes: replicate the right-aligned data so any enabled lane picks up the right bytes.
  always_comb begin
    be     = 4'b0000;
    wlanes = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        be     = 4'b0001 << req_addr[1:0];
        wlanes = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be     = req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!(accept && req_we) || acc_err) begin
      be = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem_q[req_addr[ADDR_W+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // In IDLE the read path looks at the live request so a zero-wait build can respond immediately.
  always_comb begin
    if (state_q == ST_IDLE) begin
      rd_addr = req_addr[ADDR_W+1:0];
      rd_size = req_size;
      rd_uns  = req_unsigned;
      rd_we   = req_we;
      rd_err  = acc_err;
    end else begin
      rd_addr = addr_q;
      rd_size = size_q;
      rd_uns  = uns_q;
      rd_we   = we_q;
      rd_err  = err_q;
    end
  end

  assign rd_word = mem_q[rd_addr[ADDR_W+1:2]];

  dm_lane_ext u_lane_ext (
    .word        (rd_word),
    .size        (rd_size),
    .is_unsigned (rd_uns),
    .off         (rd_addr[1:0]),
    .data        (rd_ext)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d   = req_we;
          size_d = req_size;
          uns_d  = req_unsigned;
          addr_d = req_addr[ADDR_W+1:0];
          err_d  = acc_err;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Response payload is captured once on entry to RESP and cleared when leaving it.
    if (state_d == ST_RESP && state_q != ST_RESP) begin
      rsp_err_d   = rd_err;
      rsp_rdata_d = (rd_we || rd_err) ? 32'h0 : rd_ext;
    end else if (state_d != ST_RESP) begin
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'h0;
    end

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a WAIT_CYCLES=2 instance for function, backpressure and reset,
// plus a WAIT_CYCLES=0 instance for zero-wait latency and back-to-back spacing.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        vld2 = 1'b0, rr2 = 1'b0, rdy2, val2, err2;
  logic [31:0] rdata2;
  logic        vld0 = 1'b0, rr0 = 1'b0, rdy0, val0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(vld2), .req_ready(rdy2), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(val2), .rsp_ready(rr2), .rsp_rdata(rdata2), .rsp_err(err2)
  );

  dm_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(vld0), .req_ready(rdy0), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(val0), .rsp_ready(rr0), .rsp_rdata(rdata0), .rsp_err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction. lat = k where the datapath edge T+k is the first to see rsp_valid,
  // sampled at the negedge before that edge. acc = cycle stamp of the acceptance edge.
  task automatic xact(input bit sel0, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er, output int acc);
    int guard;
    lat = -1;
    rd  = 32'hxxxxxxxx;
    er  = 1'bx;
    @(negedge clk);
    guard = 0;
    while (!(sel0 ? rdy0 : rdy2) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    if (sel0) vld0 = 1'b1; else vld2 = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    vld0 = 1'b0;
    vld2 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (sel0 ? val0 : val2) begin
        lat = k;
        rd  = sel0 ? rdata0 : rdata2;
        er  = sel0 ? err0 : err2;
        break;
      end
    end
    if (sel0) rr0 = 1'b1; else rr2 = 1'b1;
    @(posedge clk);
    #1;
    rr0 = 1'b0;
    rr2 = 1'b0;
  endtask

  initial begin
    int lat, acc, acc_prev, guard;
    logic [31:0] rd;
    logic er, seen;

    // Reset state
    #1;
    chk("rst_req_ready", 32'(rdy2), 32'd0);
    chk("rst_rsp_valid", 32'(val2), 32'd0);
    chk("rst_rsp_rdata", rdata2, 32'h0);
    chk("rst_rsp_err", 32'(err2), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy2), 32'd1);

    // Word store then load
    xact(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, acc);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_rdata", rd, 32'h0);
    xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, acc);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);

    // Byte lanes
    xact(0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000007F, lat, rd, er, acc);
    chk("sb_err", 32'(er), 32'd0);
    xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, acc);
    chk("lw_after_sb", rd, 32'hDE7FBEEF);
    xact(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er, acc);
    chk("lb_13", rd, 32'hFFFFFFDE);
    xact(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er, acc);
    chk("lbu_13", rd, 32'h000000DE);
    xact(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er, acc);
    chk("lh_12", rd, 32'hFFFFDE7F);
    xact(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er, acc);
    chk("lhu_12", rd, 32'h0000DE7F);

    // Misalignment and reserved size
    xact(0, 1'b1, 2'b10, 1'b0, 32'h11, 32'h11111111, lat, rd, er, acc);
    chk("sw_mis_err", 32'(er), 32'd1);
    chk("sw_mis_rdata", rd, 32'h0);
    xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, acc);
    chk("lw_after_mis", rd, 32'hDE7FBEEF);
    xact(0, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, lat, rd, er, acc);
    chk("lh_mis_err", 32'(er), 32'd1);
    chk("lh_mis_rdata", rd, 32'h0);
    xact(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, er, acc);
    chk("rsvd_err", 32'(er), 32'd1);

    // Backpressure: response held for 5 cycles while request inputs wander
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    vld2 = 1'b1;
    @(posedge clk);
    #1 vld2 = 1'b0;
    guard = 0;
    while (!val2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_valid_up", 32'(val2), 32'd1);
    req_addr = 32'h3;
    req_size = 2'b11;
    req_unsigned = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(val2), 32'd1);
      chk("bp_rdata_hold", rdata2, 32'hDE7FBEEF);
      chk("bp_ready_low", 32'(rdy2), 32'd0);
    end
    rr2 = 1'b1;
    @(posedge clk);
    #1 rr2 = 1'b0;
    @(negedge clk);
    chk("bp_valid_fall", 32'(val2), 32'd0);
    chk("bp_rdata_clr", rdata2, 32'h0);
    chk("bp_ready_back", 32'(rdy2), 32'd1);

    // Reset during WAIT after a store was committed
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    vld2 = 1'b1;
    @(posedge clk);
    #1 vld2 = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(rdy2), 32'd0);
    chk("midrst_valid", 32'(val2), 32'd0);
    chk("midrst_rdata", rdata2, 32'h0);
    chk("midrst_err", 32'(err2), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (val2) seen = 1'b1;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    chk("midrst_ready_after", 32'(rdy2), 32'd1);
    xact(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er, acc);
    chk("store_survives_rst", rd, 32'hCAFEF00D);

    // Address wrap modulo depth
    xact(0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h00001234, lat, rd, er, acc);
    xact(0, 1'b0, 2'b10, 1'b0, 32'h0000, 32'h0, lat, rd, er, acc);
    chk("wrap_rdata", rd, 32'h00001234);

    // Zero-wait instance
    xact(1, 1'b1, 2'b10, 1'b0, 32'h4, 32'h55AA33CC, lat, rd, er, acc);
    chk("w0_sw_lat", 32'(lat), 32'd1);
    xact(1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rd, er, acc_prev);
    chk("w0_lw1_lat", 32'(lat), 32'd1);
    chk("w0_lw1_rdata", rd, 32'h55AA33CC);
    xact(1, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, lat, rd, er, acc);
    chk("w0_lb_rdata", rd, 32'h00000033);
    chk("w0_spacing1", 32'(acc - acc_prev), 32'd2);
    acc_prev = acc;
    xact(1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, lat, rd, er, acc);
    chk("w0_lh_rdata", rd, 32'h000055AA);
    chk("w0_lh_lat", 32'(lat), 32'd1);
    chk("w0_spacing2", 32'(acc - acc_prev), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
